apb_rr_master_arbiter: RTL and testbench

Shares one APB master port among `NUM_REQ` local requesters (event reporters, config agents), using round-robin arbitration. It sequences each granted request through the APB IDLE/SETUP/ACCESS protocol. A per-transfer timeout guards against a hung slave. Completion status and read data are returned to the requester that was granted.

---
 rtl/apb_rr_master_arbiter_pkg.sv | 26 ++
 rtl/apb_rr_master_arbiter_rr.sv | 25 ++
 rtl/apb_rr_master_arbiter.sv | 123 ++++++++++++
 tb/tb_apb_rr_master_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_rr_master_arbiter_pkg.sv
// apb_arb_pkg: shared FSM state, response record and request-bus slicing helper
// for the round-robin APB master arbiter.
package apb_arb_pkg;

    localparam int MAX_W   = 64;
    localparam int MAX_REQ = 8;
    localparam int BUS_W   = MAX_W * MAX_REQ;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic             err;
        logic [MAX_W-1:0] rdata;
    } rsp_t;

    // Field idx of width w from a flattened bus; the caller truncates to w bits.
    function automatic logic [MAX_W-1:0] slice_field(input logic [BUS_W-1:0] bus,
                                                     input int idx, input int w);
        return MAX_W'(bus >> (idx * w));
    endfunction

endpackage

// File: rtl/apb_rr_master_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick of the first requester strictly after
// last_grant; the pointer register lives in the parent.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    // Walk from farthest to nearest so the nearest requester overwrites the rest.
    always_comb begin
        gnt_idx = last_grant;
        for (int i = N; i >= 1; i--) begin
            if (req[IW'((int'(last_grant) + i) % N)]) gnt_idx = IW'((int'(last_grant) + i) % N);
        end
    end

    assign any = |req;
    assign gnt = any ? (N'(1) << gnt_idx) : '0;

endmodule

// File: rtl/apb_rr_master_arbiter.sv
// apb_rr_master_arbiter: shares one APB master port among NUM_REQ requesters with
// round-robin grants, an ACCESS-phase timeout and per-requester completion pulses.
module apb_rr_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    input  logic [NUM_REQ-1:0]          req_write_i,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_wdata_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    output logic [NUM_REQ-1:0]          rsp_valid_o,
    output logic [DATA_W-1:0]           rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        apb_psel_o,
    output logic                        apb_penable_o,
    output logic                        apb_pwrite_o,
    output logic [ADDR_W-1:0]           apb_paddr_o,
    output logic [DATA_W-1:0]           apb_pwdata_o,
    input  logic                        apb_pready_i,
    input  logic                        apb_pslverr_i,
    input  logic [DATA_W-1:0]           apb_prdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    apb_state_t           state_q;
    logic [IDX_W-1:0]     last_grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     gnt_idx;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 any_req;
    logic                 psel_q;
    logic                 penable_q;
    logic                 pwrite_q;
    logic [ADDR_W-1:0]    paddr_q;
    logic [DATA_W-1:0]    pwdata_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 timeout;
    logic                 unused_rsp;
    rsp_t                 rsp_q;

    rr_arbiter #(.N(NUM_REQ), .IW(IDX_W)) u_rr (
        .req        (req_valid_i),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            idx_q        <= '0;
            cnt_q        <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            rsp_valid_q  <= '0;
            rsp_q        <= '0;
        end else begin
            rsp_valid_q <= '0;
            case (state_q)
                ST_IDLE: if (any_req) begin
                    state_q      <= ST_SETUP;
                    last_grant_q <= gnt_idx;
                    idx_q        <= gnt_idx;
                    pwrite_q     <= req_write_i[gnt_idx];
                    paddr_q      <= ADDR_W'(slice_field(BUS_W'(req_addr_i), int'(gnt_idx), ADDR_W));
                    pwdata_q     <= DATA_W'(slice_field(BUS_W'(req_wdata_i), int'(gnt_idx), DATA_W));
                    psel_q       <= 1'b1;
                end
                ST_SETUP: begin
                    state_q   <= ST_ACCESS;
                    penable_q <= 1'b1;
                    cnt_q     <= '0;
                end
                ST_ACCESS: if (apb_pready_i || timeout) begin
                    // pready takes priority over a coincident timeout
                    state_q     <= ST_IDLE;
                    psel_q      <= 1'b0;
                    penable_q   <= 1'b0;
                    rsp_valid_q <= NUM_REQ'(1) << idx_q;
                    rsp_q.err   <= apb_pready_i ? apb_pslverr_i : 1'b1;
                    rsp_q.rdata <= (apb_pready_i && !pwrite_q) ? MAX_W'(apb_prdata_i) : '0;
                end else if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o   = (reset && state_q == ST_IDLE) ? gnt : '0;
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o   = rsp_q.rdata[DATA_W-1:0];
    assign rsp_err_o     = rsp_q.err;
    assign apb_psel_o    = psel_q;
    assign apb_penable_o = penable_q;
    assign apb_pwrite_o  = pwrite_q;
    assign apb_paddr_o   = paddr_q;
    assign apb_pwdata_o  = pwdata_q;
    assign unused_rsp    = ^rsp_q;

endmodule

// File: tb/tb_apb_rr_master_arbiter.sv
// tb_apb_rr_master_arbiter: directed and randomized checks of the APB round-robin
// arbiter against a transaction-level model kept in the bench.
module tb_apb_rr_master_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 0;
    logic          reset = 0;
    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]  req_ready, rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err, psel, penable, pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic          pready = 0, pslverr = 0;
    logic [DW-1:0] prdata = '0;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [N-1:0] ready_seen = '0;

    bit            m_busy = 0, m_pend = 0, m_write = 0, m_err = 0;
    int            m_last = N - 1, m_who = 0, m_pick = -1, m_gcyc = 0, m_el = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_rdata = '0;
    logic [N-1:0]  e_ready, e_rsp;

    apb_rr_master_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid_i(req_valid), .req_write_i(req_write), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .apb_psel_o(psel), .apb_penable_o(penable), .apb_pwrite_o(pwrite),
        .apb_paddr_o(paddr), .apb_pwdata_o(pwdata),
        .apb_pready_i(pready), .apb_pslverr_i(pslverr), .apb_prdata_i(prdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[k] = 1'b1;
        req_write[k] = w;
        req_addr[k*AW +: AW] = a;
        req_wdata[k*DW +: DW] = d;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            req_valid = req_valid & ~ready_seen;
            pready = 1'b1;
            pslverr = 1'b0;
        end
    endtask

    task automatic do_reset();
        step();
        reset = 0;
        req_valid = '0;
        pready = 0;
        pslverr = 0;
        @(negedge clk);
        chk("reset_psel", psel, 0);
        chk("reset_ready", req_ready, 0);
        step();
        step();
        reset = 1;
    endtask

    // Transaction-level model: grant cycle and elapsed cycle count stand in for phases.
    always @(negedge clk) begin
        cyc++;
        ready_seen = req_ready;
        if (!reset) begin
            m_busy = 0; m_pend = 0; m_last = N - 1; m_addr = '0; m_wdata = '0; m_write = 0;
            chk("m_rst_ctrl", {req_ready, rsp_valid, psel, penable, pwrite, rsp_err}, '0);
            chk("m_rst_paddr", paddr, '0);
            chk("m_rst_pwdata", pwdata, '0);
            chk("m_rst_rdata", rsp_rdata, '0);
        end else begin
            m_pick = -1;
            if (!m_busy)
                for (int i = 1; i <= N; i++)
                    if (m_pick < 0 && req_valid[(m_last + i) % N]) m_pick = (m_last + i) % N;
            m_el = cyc - m_gcyc;
            e_ready = '0;
            if (m_pick >= 0) e_ready[m_pick] = 1'b1;
            e_rsp = '0;
            if (m_pend) e_rsp[m_who] = 1'b1;
            chk("m_ready", req_ready, e_ready);
            chk("m_psel", psel, m_busy);
            chk("m_penable", penable, m_busy && m_el >= 2);
            chk("m_paddr", paddr, m_addr);
            chk("m_pwdata", pwdata, m_wdata);
            chk("m_pwrite", pwrite, m_write);
            chk("m_rsp_valid", rsp_valid, e_rsp);
            if (m_pend) begin
                chk("m_rsp_rdata", rsp_rdata, m_rdata);
                chk("m_rsp_err", rsp_err, m_err);
            end
            m_pend = 0;
            if (m_pick >= 0) begin
                m_busy = 1; m_gcyc = cyc; m_who = m_pick; m_last = m_pick;
                m_addr = req_addr[m_pick*AW +: AW];
                m_wdata = req_wdata[m_pick*DW +: DW];
                m_write = req_write[m_pick];
            end else if (m_busy && m_el >= 2) begin
                if (pready) begin
                    m_busy = 0; m_pend = 1; m_err = pslverr;
                    m_rdata = m_write ? '0 : prdata;
                end else if (m_el - 1 == TO) begin
                    m_busy = 0; m_pend = 1; m_err = 1; m_rdata = '0;
                end
            end
        end
    end

    int gidx[5];
    int gcyc[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int g, acc;

    initial begin
        do_reset();

        // single write from requester 2
        step(); set_req(2, 1'b1, 32'hCAFE_0000, 32'h5); pready = 1;
        @(negedge clk); chk("t1_ready", req_ready, 4'b0100);
        step(); req_valid = '0;
        @(negedge clk);
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_penable", penable, 0);
        chk("t1_paddr", paddr, 32'hCAFE_0000);
        chk("t1_pwdata", pwdata, 32'h5);
        chk("t1_pwrite", pwrite, 1);
        step(); @(negedge clk); chk("t1_access_penable", penable, 1);
        step(); @(negedge clk);
        chk("t1_rsp_valid", rsp_valid, 4'b0100);
        chk("t1_rsp_err", rsp_err, 0);

        // all four requesters continuously valid, zero-wait slave
        do_reset();
        step();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(32'h100 + k * 16), '0);
        pready = 1;
        g = 0;
        for (int i = 0; i < 5; i++) begin gidx[i] = -1; gcyc[i] = -1; end
        for (int c = 0; c < 16; c++) begin
            if (c > 0) step();
            @(negedge clk);
            if (req_ready != '0 && g < 5) begin
                for (int k = 0; k < N; k++) if (req_ready[k]) gidx[g] = k;
                gcyc[g] = c;
                g++;
            end
        end
        chk("t2_grant_count", g, 5);
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", gidx[i], exp_order[i]);
            if (i > 0) chk("t2_gap", gcyc[i] - gcyc[i-1], 3);
        end
        drain(20);

        // read from requester 1, pready after three wait cycles
        step(); req_valid = '0; set_req(1, 1'b0, 32'h0000_1000, '0); pready = 0; acc = 0;
        @(negedge clk); chk("t3_ready", req_ready, 4'b0010);
        for (int i = 1; i <= 6; i++) begin
            step(); req_valid = '0; pready = (i == 5);
            prdata = (i == 5) ? 32'hDEAD_BEEF : 32'h0BAD_F00D;
            @(negedge clk); if (penable) acc++;
        end
        chk("t3_access_cycles", acc, 4);
        chk("t3_rsp_valid", rsp_valid, 4'b0010);
        chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t3_rsp_err", rsp_err, 0);

        // hung slave: timeout after TO access cycles
        step(); set_req(3, 1'b0, 32'h0000_3000, '0); pready = 0; prdata = 32'hFFFF_FFFF; acc = 0;
        for (int i = 1; i <= 18; i++) begin
            step(); req_valid = '0;
            @(negedge clk); if (penable) acc++;
        end
        chk("t4_access_cycles", acc, 16);
        chk("t4_rsp_valid", rsp_valid, 4'b1000);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        chk("t4_psel", psel, 0);

        // pready with pslverr on the final timeout cycle
        step(); set_req(2, 1'b0, 32'h0000_2000, '0); pready = 0; prdata = 32'h1234_5678; acc = 0;
        for (int i = 1; i <= 18; i++) begin
            step(); req_valid = '0; pready = (i == 17); pslverr = (i == 17);
            @(negedge clk); if (penable) acc++;
        end
        chk("t5_access_cycles", acc, 16);
        chk("t5_rsp_valid", rsp_valid, 4'b0100);
        chk("t5_rsp_err", rsp_err, 1);
        chk("t5_rsp_rdata", rsp_rdata, 32'h1234_5678);
        pready = 0; pslverr = 0;

        // reset during ACCESS
        step(); set_req(0, 1'b0, 32'h0000_0040, '0);
        @(negedge clk); chk("t6_ready", req_ready, 4'b0001);
        step(); req_valid = '0;
        step(); @(negedge clk); chk("t6_in_access", penable, 1);
        step(); reset = 0; set_req(0, 1'b0, 32'h44, '0); set_req(3, 1'b1, 32'h48, 32'h9);
        #1; chk("t6_async_psel", psel, 0);
        @(negedge clk);
        chk("t6_rst_ready", req_ready, 0);
        chk("t6_rst_penable", penable, 0);
        chk("t6_rst_paddr", paddr, 0);
        step(); step(); reset = 1; pready = 1;
        @(negedge clk);
        chk("t6_tie_ready", req_ready, 4'b0001);
        chk("t6_no_rsp", rsp_valid, 0);
        drain(20);

        // randomized traffic
        req_valid = '0;
        for (int c = 0; c < 3000; c++) begin
            step();
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && ready_seen[k]) begin
                    if ($urandom_range(0, 3) == 0) set_req(k, 1'($urandom_range(0, 1)), $urandom(), $urandom());
                    else req_valid[k] = 1'b0;
                end else if (req_valid[k]) begin
                    if ($urandom_range(0, 15) == 0) req_valid[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    set_req(k, 1'($urandom_range(0, 1)), $urandom(), $urandom());
                end
            end
            pready = ((c % 150) < 40) ? 1'b0 : ($urandom_range(0, 2) != 0);
            pslverr = ($urandom_range(0, 3) == 0);
            prdata = $urandom();
            if (c == 1700) reset = 0;
            if (c == 1702) reset = 1;
        end
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
